// File: rtl/mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter_if
// Purpose  : Request/response and multiplier-side bundle for mul_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_arbiter_if #(
  parameter int WIDTH = 64
);
  logic                 req_valid_0;
  logic                 req_valid_1;
  logic                 req_ready_0;
  logic                 req_ready_1;
  logic [WIDTH-1:0]     req_a_0;
  logic [WIDTH-1:0]     req_a_1;
  logic [WIDTH-1:0]     req_b_0;
  logic [WIDTH-1:0]     req_b_1;
  logic                 resp_valid_0;
  logic                 resp_valid_1;
  logic                 resp_ready_0;
  logic                 resp_ready_1;
  logic [2*WIDTH-1:0]   resp_data;
  logic                 resp_err;
  logic                 busy;
  logic                 grant_id;
  logic                 mul_op_start;
  logic                 mul_op_clear;
  logic [WIDTH-1:0]     mul_multiplicand;
  logic [WIDTH-1:0]     mul_multiplier;
  logic                 mul_op_done;
  logic [2*WIDTH-1:0]   mul_result;

  // Arbiter side.
  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    input  resp_ready_0, resp_ready_1, mul_op_done, mul_result,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
    output resp_data, resp_err, busy, grant_id,
    output mul_op_start, mul_op_clear, mul_multiplicand, mul_multiplier
  );

  // Client/multiplier environment side.
  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    output resp_ready_0, resp_ready_1, mul_op_done, mul_result,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
    input  resp_data, resp_err, busy, grant_id,
    input  mul_op_start, mul_op_clear, mul_multiplicand, mul_multiplier
  );
endinterface
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin sharing of one sequential signed multiplier by two ports.
// Revision : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 128
) (
  input  logic          clk,
  input  logic          reset,
  mul_arbiter_if.slave  bus
);

  localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CLEAR = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_grant;
  logic                 r_grant_id;
  logic [WIDTH-1:0]     r_multiplicand;
  logic [WIDTH-1:0]     r_multiplier;
  logic [2*WIDTH-1:0]   r_resp_data;
  logic                 r_resp_err;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_gnt_0;
  logic                 w_gnt_1;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_resp_ready_sel;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    if (bus.req_valid_0 && bus.req_valid_1) begin
      w_gnt_0 = r_last_grant;
      w_gnt_1 = ~r_last_grant;
    end else begin
      w_gnt_0 = bus.req_valid_0;
      w_gnt_1 = bus.req_valid_1;
    end
  end

  assign w_accept         = (r_state == S_IDLE) && (w_gnt_0 || w_gnt_1);
  assign w_timeout        = (r_count == c_CNT_LAST);
  assign w_resp_ready_sel = r_grant_id ? bus.resp_ready_1 : bus.resp_ready_0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.req_ready_0  = 1'b0;
    bus.req_ready_1  = 1'b0;
    bus.mul_op_start = 1'b0;
    bus.mul_op_clear = 1'b0;
    bus.resp_valid_0 = 1'b0;
    bus.resp_valid_1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready_0 = w_gnt_0;
        bus.req_ready_1 = w_gnt_1;
        if (w_accept) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        bus.mul_op_start = 1'b1;
        if (bus.mul_op_done || w_timeout) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.mul_op_clear = 1'b1;
        w_state_nxt      = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid_0 = ~r_grant_id;
        bus.resp_valid_1 = r_grant_id;
        if (w_resp_ready_sel) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, grant bookkeeping, watchdog counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant   <= 1'b1;
      r_grant_id     <= 1'b0;
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_resp_data    <= '0;
      r_resp_err     <= 1'b0;
      r_count        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_multiplicand <= w_gnt_1 ? bus.req_a_1 : bus.req_a_0;
            r_multiplier   <= w_gnt_1 ? bus.req_b_1 : bus.req_b_0;
            r_grant_id     <= w_gnt_1;
            r_last_grant   <= w_gnt_1;
            r_count        <= '0;
          end
        end
        S_START: begin
          r_count <= r_count + c_CNT_W'(1);
          // A done arriving on the final watchdog cycle still counts as success.
          if (bus.mul_op_done) begin
            r_resp_data <= bus.mul_result;
            r_resp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mul_multiplicand = r_multiplicand;
  assign bus.mul_multiplier   = r_multiplier;
  assign bus.resp_data        = r_resp_data;
  assign bus.resp_err         = r_resp_err;
  assign bus.grant_id         = r_grant_id;
  assign bus.busy             = (r_state != S_IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.mul_op_start && bus.mul_op_clear));
      assert (!(bus.req_ready_0 && bus.req_ready_1));
    end
  end
`endif

endmodule
`default_nettype wire
